// File: rtl/apb_mailbox_slave.sv
// APB completer exposing a 32-bit FIFO mailbox through CTRL/STATUS/TXDATA/RXDATA
// word registers, with configurable wait states, PSLVERR on bad accesses and an irq.
module apb_mailbox_slave #(
  parameter int ADDR_W      = 12,
  parameter int DEPTH       = 4,
  parameter int WAIT_STATES = 0
) (
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic              PSEL,
  input  logic              PENABLE,
  input  logic              PWRITE,
  input  logic [ADDR_W-1:0] PADDR,
  input  logic [31:0]       PWDATA,
  output logic [31:0]       PRDATA,
  output logic              PREADY,
  output logic              PSLVERR,
  output logic              irq
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int WCNT_W = 4;

  typedef enum logic {IDLE, ACCESS} state_t;
  typedef enum logic [1:0] {REG_CTRL, REG_STATUS, REG_TXDATA, REG_RXDATA} reg_t;

  state_t              state, state_n;
  logic [WCNT_W-1:0]   wcnt, wcnt_n;
  logic                ready_n, err_n;
  logic [31:0]         rdata_n;
  logic                commit;

  logic                ctrl_en, ctrl_en_n;
  logic [31:0]         mem [DEPTH];
  logic [PTR_W-1:0]    wr_ptr, rd_ptr;
  logic [CNT_W-1:0]    count, count_n;
  logic                empty, full;

  logic                addr_bad;
  reg_t                reg_sel;
  logic [31:0]         rsp_data;
  logic                rsp_err;
  logic [31:0]         status_word;
  logic                do_commit, push, pop, ctrl_wr, flush;
  logic                unused_addr_bits;

  assign unused_addr_bits = ^PADDR[1:0];
  assign addr_bad         = |PADDR[ADDR_W-1:4];
  assign reg_sel          = reg_t'(PADDR[3:2]);
  assign empty            = (count == '0);
  assign full             = (count == CNT_W'(DEPTH));
  assign status_word      = {16'd0, 8'(count), 6'd0, full, empty};

  // Response the current address/direction would get from the present FIFO/CTRL state.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    rsp_data = '0;
    rsp_err  = 1'b0;
    if (addr_bad) begin
      rsp_err = 1'b1;
    end else begin
      case (reg_sel)
        REG_CTRL:   if (!PWRITE) rsp_data = {31'd0, ctrl_en};
        REG_STATUS: if (PWRITE) rsp_err = 1'b1;
                    else        rsp_data = status_word;
        REG_TXDATA: if (PWRITE) rsp_err = full;
        REG_RXDATA: if (PWRITE || empty) rsp_err = 1'b1;
                    else                 rsp_data = mem[rd_ptr];
        default:    rsp_err = 1'b1;
      endcase
    end
  end

  always_comb begin
    state_n = state;
    wcnt_n  = wcnt;
    ready_n = PREADY;
    rdata_n = PRDATA;
    err_n   = PSLVERR;
    commit  = 1'b0;
    case (state)
      IDLE: begin
        if (PSEL && !PENABLE) begin
          state_n = ACCESS;
          wcnt_n  = WCNT_W'(WAIT_STATES);
          if (WAIT_STATES == 0) begin
            ready_n = 1'b1;
            rdata_n = rsp_data;
            err_n   = rsp_err;
          end
        end
      end
      ACCESS: begin
        if (!PSEL || (PREADY && !PENABLE)) begin
          // Abandoned transfer: drop the response, no side effect.
          state_n = IDLE;
          wcnt_n  = '0;
          ready_n = 1'b0;
          rdata_n = '0;
          err_n   = 1'b0;
        end else if (PREADY) begin
          commit  = 1'b1;
          state_n = IDLE;
          ready_n = 1'b0;
          rdata_n = '0;
          err_n   = 1'b0;
        end else if (wcnt != '0) begin
          wcnt_n = wcnt - 1'b1;
          if (wcnt == WCNT_W'(1)) begin
            ready_n = 1'b1;
            rdata_n = rsp_data;
            err_n   = rsp_err;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge PCLK) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (!PRESET) begin
      state   <= IDLE;
      wcnt    <= '0;
      PREADY  <= 1'b0;
      PRDATA  <= '0;
      PSLVERR <= 1'b0;
    end else begin
      state   <= state_n;
      wcnt    <= wcnt_n;
      PREADY  <= ready_n;
      PRDATA  <= rdata_n;
      PSLVERR <= err_n;
    end
  end

  // Rejected transfers were answered with PSLVERR and must leave state untouched.
  assign do_commit = commit && !PSLVERR && !addr_bad;
  assign push      = do_commit && PWRITE  && (reg_sel == REG_TXDATA) && !full;
  assign pop       = do_commit && !PWRITE && (reg_sel == REG_RXDATA) && !empty;
  assign ctrl_wr   = do_commit && PWRITE  && (reg_sel == REG_CTRL);
  assign flush     = ctrl_wr && PWDATA[1];

  always_comb begin
    ctrl_en_n = ctrl_wr ? PWDATA[0] : ctrl_en;
    count_n   = count;
    if (flush)     count_n = '0;
    else if (push) count_n = count + 1'b1;
    else if (pop)  count_n = count - 1'b1;
  end

  always_ff @(posedge PCLK) begin
    if (!PRESET) begin
      ctrl_en <= 1'b0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      irq     <= 1'b0;
    end else begin
      ctrl_en <= ctrl_en_n;
      count   <= count_n;
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
      end
      irq <= ctrl_en_n && (count_n != '0);
    end
  end

  // NOTE: the storage array is not reset; pointers and count define what is valid.
  always_ff @(posedge PCLK) begin
    if (PRESET && push) mem[wr_ptr] <= PWDATA;
  end

endmodule

// File: tb/tb_apb_mailbox_slave.sv
// Bench for apb_mailbox_slave: a zero-wait and a two-wait instance checked every cycle
// against a queue-based mailbox model, plus directed literal expectations.
module tb_apb_mailbox_slave;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        prst = 1'b0;
  logic [1:0]  psel = '0;
  logic        penable = 1'b0;
  logic        pwrite = 1'b0;
  logic [11:0] paddr = '0;
  logic [31:0] pwdata = '0;
  logic [31:0] prdata [2];
  logic        pready [2];
  logic        pslverr [2];
  logic        irq_o [2];

  int checks = 0;
  int errors = 0;

  // Model state: one queue and an enable bit per instance, plus current transfer phase.
  logic [31:0] q0 [$];
  logic [31:0] q1 [$];
  logic        m_en [2];
  int          cur = -1;
  int          acc = 0;
  bit          armed = 1'b0;

  always #5 clk = ~clk;

  apb_mailbox_slave #(.ADDR_W(12), .DEPTH(DEPTH), .WAIT_STATES(0)) u_dut0 (
    .PCLK(clk), .PRESET(prst), .PSEL(psel[0]), .PENABLE(penable), .PWRITE(pwrite),
    .PADDR(paddr), .PWDATA(pwdata), .PRDATA(prdata[0]), .PREADY(pready[0]),
    .PSLVERR(pslverr[0]), .irq(irq_o[0])
  );

  apb_mailbox_slave #(.ADDR_W(12), .DEPTH(DEPTH), .WAIT_STATES(2)) u_dut1 (
    .PCLK(clk), .PRESET(prst), .PSEL(psel[1]), .PENABLE(penable), .PWRITE(pwrite),
    .PADDR(paddr), .PWDATA(pwdata), .PRDATA(prdata[1]), .PREADY(pready[1]),
    .PSLVERR(pslverr[1]), .irq(irq_o[1])
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic int ws(input int d);
    return (d == 0) ? 0 : 2;
  endfunction

  function automatic int qsize(input int d);
    return (d == 0) ? q0.size() : q1.size();
  endfunction

  // {err, data} a correct mailbox must answer for this access right now.
  function automatic logic [32:0] model_rsp(input int d, input logic wr, input logic [11:0] a);
    int n;
    logic [31:0] head;
    n = qsize(d);
    head = '0;
    if (n != 0) head = (d == 0) ? q0[0] : q1[0];
    if (a[11:4] != 8'd0) return {1'b1, 32'd0};
    case (a[3:2])
      2'd0:    return wr ? {1'b0, 32'd0} : {1'b0, 31'd0, m_en[d]};
      2'd1:    return wr ? {1'b1, 32'd0} : {1'b0, 16'd0, 8'(n), 6'd0, n == DEPTH, n == 0};
      2'd2:    return {wr && (n == DEPTH), 32'd0};
      default: return (wr || n == 0) ? {1'b1, 32'd0} : {1'b0, head};
    endcase
  endfunction

  function automatic void model_commit(input int d, input logic wr, input logic [11:0] a,
                                       input logic [31:0] w);
    case (a[3:2])
      2'd0: if (wr) begin
        m_en[d] = w[0];
        if (w[1]) begin
          if (d == 0) q0.delete(); else q1.delete();
        end
      end
      2'd2: if (wr) begin
        if (d == 0) q0.push_back(w); else q1.push_back(w);
      end
      2'd3: if (!wr) begin
        if (d == 0) void'(q0.pop_front()); else void'(q1.pop_front());
      end
      default: ;
    endcase
  endfunction

  function automatic void model_reset();
    q0.delete();
    q1.delete();
    m_en[0] = 1'b0;
    m_en[1] = 1'b0;
  endfunction

  // Per-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (armed) begin
      for (int d = 0; d < 2; d++) begin
        logic        exp_ready;
        logic [32:0] r;
        exp_ready = (cur == d) && (acc == ws(d) + 1);
        r = exp_ready ? model_rsp(d, pwrite, paddr) : 33'd0;
        check($sformatf("pready[%0d]", d), 32'(pready[d]), 32'(exp_ready));
        check($sformatf("prdata[%0d]", d), prdata[d], r[31:0]);
        check($sformatf("pslverr[%0d]", d), 32'(pslverr[d]), 32'(r[32]));
        check($sformatf("irq[%0d]", d), 32'(irq_o[d]), 32'(m_en[d] && qsize(d) != 0));
      end
    end
  end

  // kind: 0 normal, 1 drop PSEL at access cycle 'cut', 2 assert reset at access cycle 'cut'.
  task automatic apb(input int d, input logic wr, input logic [11:0] a, input logic [31:0] w,
                     input int kind, input int cut,
                     output logic [31:0] rdata, output logic err);
    logic [32:0] r;
    rdata = '0;
    err   = 1'b0;
    r     = '0;
    psel = '0;
    psel[d] = 1'b1;
    penable = 1'b0;
    pwrite = wr;
    paddr = a;
    pwdata = w;
    cur = d;
    acc = 0;
    @(posedge clk); #1;
    penable = 1'b1;
    for (int i = 1; i <= ws(d) + 1; i++) begin
      acc = i;
      if (kind != 0 && i == cut) begin
        if (kind == 1) begin
          psel = '0;
          penable = 1'b0;
        end else begin
          prst = 1'b0;
        end
        @(posedge clk); #1;
        if (kind == 2) model_reset();
        prst = 1'b1;
        psel = '0;
        penable = 1'b0;
        cur = -1;
        acc = 0;
        return;
      end
      if (i == ws(d) + 1) begin
        rdata = prdata[d];
        err   = pslverr[d];
        r     = model_rsp(d, wr, a);
      end
      @(posedge clk); #1;
    end
    if (!r[32]) model_commit(d, wr, a, w);
    psel = '0;
    penable = 1'b0;
    cur = -1;
    acc = 0;
  endtask

  task automatic xfer_chk(input string name, input int d, input logic wr, input logic [11:0] a,
                          input logic [31:0] w, input logic [31:0] exp_data, input logic exp_err);
    logic [31:0] rd;
    logic        er;
    apb(d, wr, a, w, 0, 0, rd, er);
    if (!wr) check({name, ".data"}, rd, exp_data);
    check({name, ".err"}, 32'(er), 32'(exp_err));
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    prst = 1'b1;
    armed = 1'b1;
    check("rst.pready", 32'(pready[0]), 32'd0);
    check("rst.irq", 32'(irq_o[0]), 32'd0);

    // Empty after reset.
    xfer_chk("status0", 0, 1'b0, 12'h004, 32'd0, 32'h0000_0001, 1'b0);

    // Two pushes, status, two pops, underflow.
    xfer_chk("push1", 0, 1'b1, 12'h008, 32'hA5A5_0001, 32'd0, 1'b0);
    xfer_chk("push2", 0, 1'b1, 12'h008, 32'hA5A5_0002, 32'd0, 1'b0);
    xfer_chk("status2", 0, 1'b0, 12'h004, 32'd0, 32'h0000_0200, 1'b0);
    xfer_chk("pop1", 0, 1'b0, 12'h00C, 32'd0, 32'hA5A5_0001, 1'b0);
    xfer_chk("pop2", 0, 1'b0, 12'h00C, 32'd0, 32'hA5A5_0002, 1'b0);
    xfer_chk("pop_empty", 0, 1'b0, 12'h00C, 32'd0, 32'd0, 1'b1);
    xfer_chk("tx_read", 0, 1'b0, 12'h008, 32'd0, 32'd0, 1'b0);

    // Fill, overflow, drain in order, then refill across the pointer wrap.
    for (int i = 0; i < DEPTH; i++)
      xfer_chk("fill", 0, 1'b1, 12'h008, 32'h1111_0000 + 32'(i), 32'd0, 1'b0);
    xfer_chk("status_full", 0, 1'b0, 12'h004, 32'd0, 32'h0000_0402, 1'b0);
    xfer_chk("push_full", 0, 1'b1, 12'h008, 32'hDEAD_BEEF, 32'd0, 1'b1);
    for (int i = 0; i < DEPTH; i++)
      xfer_chk("drain", 0, 1'b0, 12'h00C, 32'd0, 32'h1111_0000 + 32'(i), 1'b0);
    for (int i = 0; i < 3; i++)
      xfer_chk("refill", 0, 1'b1, 12'h008, 32'h2222_0000 + 32'(i), 32'd0, 1'b0);
    for (int i = 0; i < 3; i++)
      xfer_chk("wrap_pop", 0, 1'b0, 12'h00C, 32'd0, 32'h2222_0000 + 32'(i), 1'b0);

    // Interrupt enable, then flush with EN kept.
    xfer_chk("ctrl_en", 0, 1'b1, 12'h000, 32'h1, 32'd0, 1'b0);
    check("irq_idle", 32'(irq_o[0]), 32'd0);
    xfer_chk("push_irq", 0, 1'b1, 12'h008, 32'h0000_1234, 32'd0, 1'b0);
    check("irq_set", 32'(irq_o[0]), 32'd1);
    xfer_chk("ctrl_clr", 0, 1'b1, 12'h000, 32'h3, 32'd0, 1'b0);
    check("irq_clr", 32'(irq_o[0]), 32'd0);
    xfer_chk("status_clr", 0, 1'b0, 12'h004, 32'd0, 32'h0000_0001, 1'b0);
    xfer_chk("ctrl_rd", 0, 1'b0, 12'h000, 32'd0, 32'h0000_0001, 1'b0);

    // Out-of-range and illegal-direction accesses change nothing.
    xfer_chk("bad_rd", 0, 1'b0, 12'h010, 32'd0, 32'd0, 1'b1);
    xfer_chk("bad_wr", 0, 1'b1, 12'h010, 32'h3, 32'd0, 1'b1);
    xfer_chk("status_wr", 0, 1'b1, 12'h004, 32'h0, 32'd0, 1'b1);
    xfer_chk("rx_wr", 0, 1'b1, 12'h00C, 32'h55, 32'd0, 1'b1);
    xfer_chk("ctrl_kept", 0, 1'b0, 12'h000, 32'd0, 32'h0000_0001, 1'b0);
    xfer_chk("status_kept", 0, 1'b0, 12'h004, 32'd0, 32'h0000_0001, 1'b0);

    // Two wait states: abort mid-wait leaves the FIFO unchanged.
    xfer_chk("ws_push", 1, 1'b1, 12'h008, 32'hBEEF_0001, 32'd0, 1'b0);
    xfer_chk("ws_status1", 1, 1'b0, 12'h004, 32'd0, 32'h0000_0100, 1'b0);
    apb(1, 1'b1, 12'h008, 32'hBEEF_0002, 1, 2, rd, er);
    check("abort.pready", 32'(pready[1]), 32'd0);
    xfer_chk("ws_status_abort", 1, 1'b0, 12'h004, 32'd0, 32'h0000_0100, 1'b0);
    xfer_chk("ws_pop", 1, 1'b0, 12'h00C, 32'd0, 32'hBEEF_0001, 1'b0);
    xfer_chk("ws_push2", 1, 1'b1, 12'h008, 32'hCAFE_0000, 32'd0, 1'b0);

    // Reset in the middle of a waited push.
    apb(1, 1'b1, 12'h008, 32'hCAFE_0001, 2, 1, rd, er);
    check("mid_rst.pready", 32'(pready[1]), 32'd0);
    check("mid_rst.prdata", prdata[1], 32'd0);
    check("mid_rst.pslverr", 32'(pslverr[1]), 32'd0);
    check("mid_rst.irq0", 32'(irq_o[0]), 32'd0);
    xfer_chk("rst_status1", 1, 1'b0, 12'h004, 32'd0, 32'h0000_0001, 1'b0);
    xfer_chk("rst_ctrl0", 0, 1'b0, 12'h000, 32'd0, 32'h0000_0000, 1'b0);
    xfer_chk("rst_status0", 0, 1'b0, 12'h004, 32'd0, 32'h0000_0001, 1'b0);

    repeat (2) @(posedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
